// File: rtl/seg7_scan_decode.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus: each digit's
// pattern must be stable for STABLE samples, then frames are emitted on valid/ready.
module seg7_scan_decode #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  // Output handshake: a word moves when out_valid && out_ready in the same
  // cycle; out_data/out_err hold while out_valid && !out_ready, and out_valid
  // only falls after a transfer.

  logic [DIGITS-1:0][6:0] last_q, last_d;
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0] slot_nib_q, slot_nib_d;
  logic [DIGITS-1:0]      slot_err_q, slot_err_d;
  logic [DIGITS-1:0]      cap_q, cap_d;
  logic [4*DIGITS-1:0]    out_data_q, out_data_d;
  logic [DIGITS-1:0]      out_err_q, out_err_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;

  logic [4:0] dec;
  int         hot_cnt;
  logic       valid_sample;
  logic       frame_done;
  logic       transfer;

  // Returns {err, nibble}; unknown patterns (blank included) decode to 0 with err.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b0001000: return 5'h0A;
      7'b0000011: return 5'h0B;
      7'b1000110: return 5'h0C;
      7'b0100001: return 5'h0D;
      7'b0000110: return 5'h0E;
      7'b0001110: return 5'h0F;
      default:    return 5'h10;
    endcase
  endfunction

  always_comb begin
    last_d       = last_q;
    cnt_d        = cnt_q;
    slot_nib_d   = slot_nib_q;
    slot_err_d   = slot_err_q;
    cap_d        = cap_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    overrun_d    = 1'b0;
    dec          = decode_seg(seg_n);
    hot_cnt      = 0;

    for (int i = 0; i < DIGITS; i++) begin
      hot_cnt = hot_cnt + int'(dig_en[i]);
    end
    valid_sample = sample && (hot_cnt == 1);

    for (int i = 0; i < DIGITS; i++) begin
      if (valid_sample && dig_en[i]) begin
        if (seg_n != last_q[i]) begin
          last_d[i] = seg_n;
          cnt_d[i]  = 4'd1;
        end else if (cnt_q[i] < STABLE_C) begin
          cnt_d[i]  = cnt_q[i] + 4'd1;
        end
        if (cnt_d[i] >= STABLE_C) begin
          slot_nib_d[i] = dec[3:0];
          slot_err_d[i] = dec[4];
          cap_d[i]      = 1'b1;
        end
      end
    end

    frame_done = &cap_d;
    transfer   = out_valid_q && out_ready;

    // A finished frame takes the output register only if it is free this cycle.
    if (frame_done) begin
      cap_d = '0;
      if (!out_valid_q || transfer) begin
        out_data_d  = slot_nib_d;
        out_err_d   = slot_err_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= {DIGITS{7'h7F}};
      cnt_q       <= '0;
      slot_nib_q  <= '0;
      slot_err_q  <= '0;
      cap_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      slot_nib_q  <= slot_nib_d;
      slot_err_q  <= slot_err_d;
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
